// File: rtl/console_pkg.sv
// Shared types, ASCII codes and buffer address packing for the text console.
package console_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_BS = 8'h08;
    localparam logic [7:0] ASC_SP = 8'h20;

    // Buffer address layout: column in the upper bits, physical row in the lower bits.
    function automatic logic [11:0] mk_addr(input logic [6:0] col, input logic [4:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/console_fill.sv
// Row/column walker producing blank-write addresses for a single-row or full-screen clear.
module console_fill
    import console_pkg::*;
#(
    parameter int unsigned COLS = 70,
    parameter int unsigned ROWS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        all_rows,
    input  logic [4:0]  row_base,
    output logic        busy,
    output logic        done,
    output logic [11:0] addr
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    logic [6:0] col_q;
    logic [4:0] row_q;
    logic       all_q;
    logic       busy_q;

    assign busy = busy_q;
    // Asserted while the final cell of the walk is being presented.
    assign done = busy_q && (col_q == COL_LAST) && (!all_q || (row_q == ROW_LAST));
    assign addr = mk_addr(col_q, row_q);

    // Walk columns inner, rows outer; a new start restarts the walk from column 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            col_q  <= 7'd0;
            row_q  <= 5'd0;
            all_q  <= 1'b0;
        end else if (start) begin
            busy_q <= 1'b1;
            col_q  <= 7'd0;
            row_q  <= all_rows ? 5'd0 : row_base;
            all_q  <= all_rows;
        end else if (busy_q) begin
            if (col_q == COL_LAST) begin
                col_q <= 7'd0;
                if (done) begin
                    busy_q <= 1'b0;
                end else begin
                    row_q <= row_q + 5'd1;
                end
            end else begin
                col_q <= col_q + 7'd1;
            end
        end
    end

endmodule

// File: rtl/console_ctrl.sv
// Text-console write sequencer: cursor tracking, control codes and scroll-by-offset.
module console_ctrl
    import console_pkg::*;
#(
    parameter int unsigned COLS  = 70,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    input  logic        clear,
    output logic [11:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        buf_we,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic [4:0]  scroll_row,
    output logic        busy
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    state_t      state_q;
    logic        accept;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [11:0] wr_addr;
    logic [6:0]  col_d;
    logic [4:0]  row_d;
    logic [4:0]  scroll_d;
    logic        newline;
    logic        do_scroll;
    logic [4:0]  bottom_row;
    logic        fill_start;
    logic        fill_busy;
    logic        fill_done;
    logic [11:0] fill_addr;

    assign in_ready   = (state_q == IDLE) && !clear;
    assign accept     = in_valid && in_ready;
    assign bottom_row = (scroll_row == 5'd0) ? ROW_LAST : scroll_row - 5'd1;
    assign fill_start = clear || do_scroll;

    // Decode the accepted byte into an optional write and the next cursor/scroll position.
    always_comb begin
        wr_en     = 1'b0;
        wr_data   = in_char;
        wr_addr   = mk_addr(cursor_col, cursor_row);
        col_d     = cursor_col;
        row_d     = cursor_row;
        scroll_d  = scroll_row;
        newline   = 1'b0;
        do_scroll = 1'b0;
        if (accept) begin
            if (in_char >= ASC_SP && in_char <= 8'h7E) begin
                wr_en = 1'b1;
                if (cursor_col == COL_LAST) begin
                    col_d   = 7'd0;
                    newline = 1'b1;
                end else begin
                    col_d = cursor_col + 7'd1;
                end
            end else if (in_char == ASC_LF) begin
                newline = 1'b1;
            end else if (in_char == ASC_CR) begin
                col_d = 7'd0;
            end else if (in_char == ASC_BS && cursor_col != 7'd0) begin
                col_d   = cursor_col - 7'd1;
                wr_en   = 1'b1;
                wr_data = BLANK;
                wr_addr = mk_addr(cursor_col - 7'd1, cursor_row);
            end
        end
        if (newline) begin
            row_d = (cursor_row == ROW_LAST) ? 5'd0 : cursor_row + 5'd1;
            // Leaving the bottom visible row recycles the top row as the new bottom.
            if (cursor_row == bottom_row) begin
                scroll_d  = (scroll_row == ROW_LAST) ? 5'd0 : scroll_row + 5'd1;
                do_scroll = 1'b1;
            end
        end
    end

    console_fill #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_fill (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (fill_start),
        .all_rows (clear),
        .row_base (row_d),
        .busy     (fill_busy),
        .done     (fill_done),
        .addr     (fill_addr)
    );

    // Sequencer FSM with registered buffer port, cursor and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= 12'd0;
            buf_data   <= BLANK;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            scroll_row <= 5'd0;
        end else if (clear) begin
            state_q    <= CLR_ALL;
            busy       <= 1'b1;
            buf_we     <= 1'b0;
            buf_data   <= BLANK;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            scroll_row <= 5'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    buf_we <= wr_en;
                    if (wr_en) begin
                        buf_addr <= wr_addr;
                        buf_data <= wr_data;
                    end
                    cursor_col <= col_d;
                    cursor_row <= row_d;
                    scroll_row <= scroll_d;
                    if (do_scroll) begin
                        state_q <= CLR_ROW;
                        busy    <= 1'b1;
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    buf_we   <= fill_busy;
                    buf_addr <= fill_addr;
                    buf_data <= BLANK;
                    if (fill_done) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    buf_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
